// File: rtl/i2cmb_ctrl_pkg.sv
// Shared register map, CMDR command codes, status bit positions and the
// sequencer state encoding for the i2cmb command sequencer.
package i2cmb_ctrl_pkg;

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DPR  = 2'd1;
  localparam logic [1:0] REG_CMDR = 2'd2;

  localparam logic [2:0] CMD_WRITE    = 3'b001;
  localparam logic [2:0] CMD_READ_ACK = 3'b010;
  localparam logic [2:0] CMD_READ_NAK = 3'b011;
  localparam logic [2:0] CMD_START    = 3'b100;
  localparam logic [2:0] CMD_STOP     = 3'b101;
  localparam logic [2:0] CMD_SET_BUS  = 3'b110;

  localparam logic [7:0] CSR_ENABLE = 8'hC0;

  // CMDR read-back flags
  localparam int CMDR_DON_BIT = 7;
  localparam int CMDR_NAK_BIT = 6;
  localparam int CMDR_AL_BIT  = 5;
  localparam int CMDR_ERR_BIT = 4;

  // status_o = {err, al, nak}
  localparam int STS_ERR_BIT = 2;
  localparam int STS_AL_BIT  = 1;
  localparam int STS_NAK_BIT = 0;

  typedef enum logic [3:0] {
    ST_ENABLE     = 4'd0,
    ST_IDLE       = 4'd1,
    ST_BUS_DPR    = 4'd2,
    ST_CMD_WR     = 4'd3,
    ST_CMD_IRQ    = 4'd4,
    ST_CMD_RD     = 4'd5,
    ST_ADDR_DPR   = 4'd6,
    ST_WDATA_WAIT = 4'd7,
    ST_WDATA_DPR  = 4'd8,
    ST_RD_DPR     = 4'd9,
    ST_DONE       = 4'd10
  } seq_state_e;

  function automatic logic [7:0] cmdr_word(input logic [2:0] cmd);
    return {5'b00000, cmd};
  endfunction

endpackage

// File: rtl/i2cmb_wb_access.sv
// Single Wishbone access engine: launches one read or write on start_i, holds
// the bus stable until ack, then idles for at least one cycle with done_o high.
module i2cmb_wb_access
  import i2cmb_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] wdat_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdat_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       we_q, we_d;
  logic [1:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] rdat_q, rdat_d;

  always_comb begin
    active_d = active_q;
    done_d   = 1'b0;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rdat_d   = rdat_q;
    if (!active_q) begin
      if (start_i) begin
        active_d = 1'b1;
        we_d     = we_i;
        adr_d    = adr_i;
        dat_d    = wdat_i;
      end
    end else if (wb_ack_i) begin
      // cyc/stb fall here; done_o marks the mandatory idle cycle
      active_d = 1'b0;
      done_d   = 1'b1;
      rdat_d   = wb_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 2'd0;
      dat_q    <= 8'h00;
      rdat_q   <= 8'h00;
    end else begin
      active_q <= active_d;
      done_q   <= done_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      rdat_q   <= rdat_d;
    end
  end

  assign busy_o   = active_q;
  assign done_o   = done_q;
  assign rdat_o   = rdat_q;
  assign wb_cyc_o = active_q;
  assign wb_stb_o = active_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: rtl/i2cmb_cmd_sequencer.sv
// Turns byte-level I2C read/write requests into the i2cmb register command
// sequence (SET_BUS, START, address, data, STOP) over a Wishbone master port.
module i2cmb_cmd_sequencer
  import i2cmb_ctrl_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int WAIT_CSR_EN = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rw_i,
  input  logic [3:0] req_bus_i,
  input  logic [6:0] req_addr_i,
  input  logic [7:0] req_len_i,
  input  logic       wdata_valid_i,
  input  logic [7:0] wdata_i,
  output logic       wdata_ready_o,
  output logic       rdata_valid_o,
  output logic [7:0] rdata_o,
  output logic       done_o,
  output logic [2:0] status_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       irq_i
);

  localparam seq_state_e RST_STATE = (WAIT_CSR_EN != 0) ? ST_ENABLE : ST_IDLE;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  seq_state_e state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic       rw_q, rw_d;
  logic [3:0] bus_q, bus_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       addr_ph_q, addr_ph_d;
  logic [7:0] wbyte_q, wbyte_d;
  logic       bus_valid_q, bus_valid_d;
  logic [3:0] last_bus_q, last_bus_d;
  logic [2:0] sts_q, sts_d;
  logic [2:0] status_q, status_d;

  logic       acc_req, acc_start, acc_we, acc_busy, acc_done;
  logic [1:0] acc_adr;
  logic [7:0] acc_wdat, acc_rdat;

  // Handshakes: req and wdata transfer on a clock edge where valid and ready
  // are both high; wdata_ready_o is only raised for one cycle while waiting
  // for a byte. rdata_valid_o and done_o are single-cycle strobes, no backpressure.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rw_d        = rw_q;
    bus_d       = bus_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    addr_ph_d   = addr_ph_q;
    wbyte_d     = wbyte_q;
    bus_valid_d = bus_valid_q;
    last_bus_d  = last_bus_q;
    sts_d       = sts_q;
    status_d    = status_q;
    acc_req     = 1'b0;
    acc_we      = 1'b0;
    acc_adr     = REG_CSR;
    acc_wdat    = 8'h00;
    req_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    rdata_valid_o = 1'b0;
    done_o        = 1'b0;

    case (state_q)
      ST_ENABLE: begin
        acc_req  = 1'b1;
        acc_we   = 1'b1;
        acc_adr  = REG_CSR;
        acc_wdat = CSR_ENABLE;
        if (acc_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          rw_d      = req_rw_i;
          bus_d     = req_bus_i;
          addr_d    = req_addr_i;
          cnt_d     = req_len_i;
          addr_ph_d = 1'b0;
          sts_d     = 3'b000;
          if (req_len_i > MAX_LEN_B) begin
            sts_d[STS_ERR_BIT] = 1'b1;
            state_d = ST_DONE;
          end else if (!bus_valid_q || (req_bus_i != last_bus_q)) begin
            state_d = ST_BUS_DPR;
          end else begin
            cmd_d   = CMD_START;
            state_d = ST_CMD_WR;
          end
        end
      end
      ST_BUS_DPR: begin
        acc_req  = 1'b1;
        acc_we   = 1'b1;
        acc_adr  = REG_DPR;
        acc_wdat = {4'h0, bus_q};
        if (acc_done) begin
          cmd_d   = CMD_SET_BUS;
          state_d = ST_CMD_WR;
        end
      end
      ST_CMD_WR: begin
        acc_req  = 1'b1;
        acc_we   = 1'b1;
        acc_adr  = REG_CMDR;
        acc_wdat = cmdr_word(cmd_q);
        if (acc_done) state_d = ST_CMD_IRQ;
      end
      ST_CMD_IRQ: begin
        if (irq_i) state_d = ST_CMD_RD;
      end
      ST_CMD_RD: begin
        acc_req = 1'b1;
        acc_adr = REG_CMDR;
        if (acc_done) begin
          // ERR and AL abandon the transfer with no STOP
          if (acc_rdat[CMDR_ERR_BIT]) begin
            sts_d[STS_ERR_BIT] = 1'b1;
            state_d = ST_DONE;
          end else if (acc_rdat[CMDR_AL_BIT]) begin
            sts_d[STS_AL_BIT] = 1'b1;
            bus_valid_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            case (cmd_q)
              CMD_SET_BUS: begin
                bus_valid_d = 1'b1;
                last_bus_d  = bus_q;
                cmd_d       = CMD_START;
                state_d     = ST_CMD_WR;
              end
              CMD_START: state_d = ST_ADDR_DPR;
              CMD_WRITE: begin
                if (acc_rdat[CMDR_NAK_BIT]) begin
                  sts_d[STS_NAK_BIT] = 1'b1;
                  cmd_d   = CMD_STOP;
                  state_d = ST_CMD_WR;
                end else if (addr_ph_q) begin
                  addr_ph_d = 1'b0;
                  if (cnt_q == 8'd0) begin
                    cmd_d   = CMD_STOP;
                    state_d = ST_CMD_WR;
                  end else if (rw_q) begin
                    cmd_d   = (cnt_q == 8'd1) ? CMD_READ_NAK : CMD_READ_ACK;
                    state_d = ST_CMD_WR;
                  end else begin
                    state_d = ST_WDATA_WAIT;
                  end
                end else begin
                  cnt_d = cnt_q - 8'd1;
                  if (cnt_q == 8'd1) begin
                    cmd_d   = CMD_STOP;
                    state_d = ST_CMD_WR;
                  end else begin
                    state_d = ST_WDATA_WAIT;
                  end
                end
              end
              CMD_READ_ACK, CMD_READ_NAK: state_d = ST_RD_DPR;
              default: state_d = ST_DONE;
            endcase
          end
        end
      end
      ST_ADDR_DPR: begin
        acc_req  = 1'b1;
        acc_we   = 1'b1;
        acc_adr  = REG_DPR;
        acc_wdat = {addr_q, rw_q};
        if (acc_done) begin
          addr_ph_d = 1'b1;
          cmd_d     = CMD_WRITE;
          state_d   = ST_CMD_WR;
        end
      end
      ST_WDATA_WAIT: begin
        wdata_ready_o = wdata_valid_i;
        if (wdata_valid_i) begin
          wbyte_d = wdata_i;
          state_d = ST_WDATA_DPR;
        end
      end
      ST_WDATA_DPR: begin
        acc_req  = 1'b1;
        acc_we   = 1'b1;
        acc_adr  = REG_DPR;
        acc_wdat = wbyte_q;
        if (acc_done) begin
          cmd_d   = CMD_WRITE;
          state_d = ST_CMD_WR;
        end
      end
      ST_RD_DPR: begin
        acc_req = 1'b1;
        acc_adr = REG_DPR;
        if (acc_done) begin
          rdata_valid_o = 1'b1;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1)      cmd_d = CMD_STOP;
          else if (cnt_q == 8'd2) cmd_d = CMD_READ_NAK;
          else                    cmd_d = CMD_READ_ACK;
          state_d = ST_CMD_WR;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = RST_STATE;
    endcase

    if (state_d == ST_DONE) status_d = sts_d;
  end

  // The idle cycle after each ack (acc_done) keeps a new start from firing
  assign acc_start = acc_req && !acc_busy && !acc_done;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RST_STATE;
      cmd_q       <= CMD_START;
      rw_q        <= 1'b0;
      bus_q       <= 4'h0;
      addr_q      <= 7'h00;
      cnt_q       <= 8'h00;
      addr_ph_q   <= 1'b0;
      wbyte_q     <= 8'h00;
      bus_valid_q <= 1'b0;
      last_bus_q  <= 4'h0;
      sts_q       <= 3'b000;
      status_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rw_q        <= rw_d;
      bus_q       <= bus_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      addr_ph_q   <= addr_ph_d;
      wbyte_q     <= wbyte_d;
      bus_valid_q <= bus_valid_d;
      last_bus_q  <= last_bus_d;
      sts_q       <= sts_d;
      status_q    <= status_d;
    end
  end

  assign status_o = status_q;
  assign rdata_o  = acc_rdat;

  i2cmb_wb_access u_wb_access (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (acc_start),
    .we_i     (acc_we),
    .adr_i    (acc_adr),
    .wdat_i   (acc_wdat),
    .busy_o   (acc_busy),
    .done_o   (acc_done),
    .rdat_o   (acc_rdat),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

endmodule
